// File: rtl/data_mem_lsu.sv
// rtl/data_mem_lsu.sv - load/store front end for a word-wide RAM without byte enables
// Optional LSU_RANGE_CHECK_EN: error out addresses outside the data RAM window.
module data_mem_lsu #(
  parameter logic [31:0] BASE_ADDR   = 32'h10010000,
  parameter int          DEPTH_WORDS = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  output logic        rsp_err_o,
  output logic [31:0] rsp_rdata_o,
  output logic        ram_we_o,
  output logic [31:0] ram_addr_o,
  output logic [31:0] ram_data_o,
  input  logic [31:0] ram_q_i
);

  typedef enum logic [2:0] {IDLE, RD, RDW, WR, RESP} state_t;

  localparam logic [31:0] END_ADDR = BASE_ADDR + 32'(4 * DEPTH_WORDS);
`ifdef LSU_RANGE_CHECK_EN
  localparam logic RANGE_EN = 1'b1;
`else
  localparam logic RANGE_EN = 1'b0;
`endif

  state_t      state, state_d;
  logic        we_q, we_qd;
  logic [1:0]  size_q, size_qd;
  logic        uns_q, uns_qd;
  logic [1:0]  lane_q, lane_qd;
  logic [15:0] wdata_q, wdata_qd;

  logic        ready_d, rsp_valid_d, rsp_err_d, ram_we_d;
  logic [31:0] rsp_rdata_d, ram_addr_d, ram_data_d;

  logic        req_word, misalign, in_range, req_err;
  logic [4:0]  shamt;
  logic [31:0] lane_word, load_val, lane_mask, store_ins, merged;

  always_comb begin
    req_word = req_size_i[1];
    misalign = (req_size_i == 2'b01 && req_addr_i[0]) ||
               (req_word && req_addr_i[1:0] != 2'b00);
    in_range = (req_addr_i >= BASE_ADDR) && (req_addr_i < END_ADDR);
    req_err  = misalign || (RANGE_EN && !in_range);
  end

  // Lane extraction for loads and lane merge for sub-word stores.
  always_comb begin
    shamt     = {lane_q, 3'b000};
    lane_word = ram_q_i >> shamt;
    load_val  = ram_q_i;
    lane_mask = 32'h0000ffff << shamt;
    store_ins = {16'h0000, wdata_q} << shamt;
    if (size_q == 2'b00) begin
      load_val  = {{24{~uns_q & lane_word[7]}}, lane_word[7:0]};
      lane_mask = 32'h000000ff << shamt;
      store_ins = {24'h000000, wdata_q[7:0]} << shamt;
    end else if (size_q == 2'b01) begin
      load_val  = {{16{~uns_q & lane_word[15]}}, lane_word[15:0]};
    end
    merged = (ram_q_i & ~lane_mask) | store_ins;
  end

  always_comb begin
    state_d     = state;
    we_qd       = we_q;
    size_qd     = size_q;
    uns_qd      = uns_q;
    lane_qd     = lane_q;
    wdata_qd    = wdata_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = 32'h0;
    ram_we_d    = 1'b0;
    ram_addr_d  = ram_addr_o;
    ram_data_d  = 32'h0;
    case (state)
      IDLE: begin
        if (req_valid_i) begin
          we_qd    = req_we_i;
          size_qd  = req_size_i;
          uns_qd   = req_unsigned_i;
          lane_qd  = req_addr_i[1:0];
          wdata_qd = req_wdata_i[15:0];
          if (req_err) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else begin
            ram_addr_d = {req_addr_i[31:2], 2'b00};
            if (req_we_i && req_word) begin
              state_d    = WR;
              ram_we_d   = 1'b1;
              ram_data_d = req_wdata_i;
            end else begin
              state_d = RD;
            end
          end
        end
      end
      RD: state_d = RDW;
      RDW: begin
        if (we_q) begin
          state_d    = WR;
          ram_we_d   = 1'b1;
          ram_data_d = merged;
        end else begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = load_val;
        end
      end
      WR: begin
        state_d     = RESP;
        rsp_valid_d = 1'b1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      we_q        <= 1'b0;
      size_q      <= 2'b00;
      uns_q       <= 1'b0;
      lane_q      <= 2'b00;
      wdata_q     <= 16'h0;
      req_ready_o <= 1'b1;
      rsp_valid_o <= 1'b0;
      rsp_err_o   <= 1'b0;
      rsp_rdata_o <= 32'h0;
      ram_we_o    <= 1'b0;
      ram_addr_o  <= 32'h0;
      ram_data_o  <= 32'h0;
    end else begin
      state       <= state_d;
      we_q        <= we_qd;
      size_q      <= size_qd;
      uns_q       <= uns_qd;
      lane_q      <= lane_qd;
      wdata_q     <= wdata_qd;
      req_ready_o <= ready_d;
      rsp_valid_o <= rsp_valid_d;
      rsp_err_o   <= rsp_err_d;
      rsp_rdata_o <= rsp_rdata_d;
      ram_we_o    <= ram_we_d;
      ram_addr_o  <= ram_addr_d;
      ram_data_o  <= ram_data_d;
    end
  end

endmodule

// File: tb/tb_data_mem_lsu.sv
// tb/tb_data_mem_lsu.sv - directed self-checking bench for data_mem_lsu
// Range-check vectors are selected by LSU_RANGE_CHECK_EN.
module tb_data_mem_lsu;
  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err, ram_we;
  logic [31:0] rsp_rdata, ram_addr, ram_data, ram_q;

  logic [31:0] mem [0:63];
  int n_assert = 0;
  int n_fail = 0;

  int          rsp_cyc, we_cyc, we_cnt, ready_cyc;
  logic        rsp_err_s, ready_c1;
  logic [31:0] rsp_rdata_s, we_data_s, we_addr_s;

  data_mem_lsu dut (
    .clk(clk), .reset(reset),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_we_i(req_we), .req_size_i(req_size), .req_unsigned_i(req_unsigned),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid), .rsp_err_o(rsp_err), .rsp_rdata_o(rsp_rdata),
    .ram_we_o(ram_we), .ram_addr_o(ram_addr), .ram_data_o(ram_data),
    .ram_q_i(ram_q)
  );

  always #5 clk = ~clk;

  // Synchronous single-port RAM, read-before-write.
  always @(posedge clk) begin
    if (ram_we === 1'b1) mem[ram_addr[7:2]] <= ram_data;
    ram_q <= mem[ram_addr[7:2]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request at a negedge and record what happens over cycles C1..C8.
  task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd);
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = a; req_wdata = wd;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    rsp_cyc = -1; we_cyc = -1; we_cnt = 0; ready_cyc = -1;
    rsp_err_s = 1'b0; rsp_rdata_s = 32'h0; we_data_s = 32'h0; we_addr_s = 32'h0;
    ready_c1 = req_ready;
    for (int c = 1; c <= 8; c++) begin
      if (ram_we) begin we_cnt++; we_cyc = c; we_data_s = ram_data; we_addr_s = ram_addr; end
      if (rsp_valid && rsp_cyc < 0) begin rsp_cyc = c; rsp_err_s = rsp_err; rsp_rdata_s = rsp_rdata; end
      if (req_ready && ready_cyc < 0) ready_cyc = c;
      @(negedge clk);
    end
  endtask

  task automatic load_chk(input string tag, input logic [1:0] sz, input logic uns,
                          input logic [31:0] a, input logic [31:0] exp);
    issue(1'b0, sz, uns, a, 32'h0);
    chk({tag, "_rsp_cyc"}, 32'(rsp_cyc), 32'd3);
    chk({tag, "_rdata"}, rsp_rdata_s, exp);
    chk({tag, "_no_we"}, 32'(we_cnt), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_rdata", rsp_rdata, 32'h0);
    chk("rst_we", 32'(ram_we), 32'd0);
    chk("rst_addr", ram_addr, 32'h0);
    chk("rst_data", ram_data, 32'h0);

    issue(1'b1, 2'b10, 1'b0, 32'h10010004, 32'h12345678);
    chk("sw_ready_c1", 32'(ready_c1), 32'd0);
    chk("sw_we_cyc", 32'(we_cyc), 32'd1);
    chk("sw_we_cnt", 32'(we_cnt), 32'd1);
    chk("sw_we_addr", we_addr_s, 32'h10010004);
    chk("sw_we_data", we_data_s, 32'h12345678);
    chk("sw_rsp_cyc", 32'(rsp_cyc), 32'd2);
    chk("sw_rsp_err", 32'(rsp_err_s), 32'd0);
    chk("sw_ready_ret", 32'(ready_cyc), 32'd3);

    load_chk("lw", 2'b10, 1'b0, 32'h10010004, 32'h12345678);

    issue(1'b1, 2'b00, 1'b0, 32'h10010006, 32'hFFFFFFAB);
    chk("sb_we_cyc", 32'(we_cyc), 32'd3);
    chk("sb_we_cnt", 32'(we_cnt), 32'd1);
    chk("sb_we_addr", we_addr_s, 32'h10010004);
    chk("sb_we_data", we_data_s, 32'h12AB5678);
    chk("sb_rsp_cyc", 32'(rsp_cyc), 32'd4);

    load_chk("lb", 2'b00, 1'b0, 32'h10010006, 32'hFFFFFFAB);
    load_chk("lbu", 2'b00, 1'b1, 32'h10010006, 32'h000000AB);
    load_chk("lh", 2'b01, 1'b0, 32'h10010006, 32'h000012AB);
    load_chk("lh_lo", 2'b01, 1'b0, 32'h10010004, 32'h00005678);
    load_chk("lb_top", 2'b00, 1'b0, 32'h10010007, 32'h00000012);
    load_chk("lw_size11_uns", 2'b11, 1'b1, 32'h10010004, 32'h12AB5678);

    issue(1'b1, 2'b01, 1'b0, 32'h10010004, 32'hDEAD8001);
    chk("sh_we_cyc", 32'(we_cyc), 32'd3);
    chk("sh_we_data", we_data_s, 32'h12AB8001);
    chk("sh_rsp_cyc", 32'(rsp_cyc), 32'd4);
    load_chk("lh_neg", 2'b01, 1'b0, 32'h10010004, 32'hFFFF8001);
    load_chk("lhu_neg", 2'b01, 1'b1, 32'h10010004, 32'h00008001);

    issue(1'b0, 2'b01, 1'b0, 32'h10010001, 32'h0);
    chk("mis_lh_rsp_cyc", 32'(rsp_cyc), 32'd1);
    chk("mis_lh_err", 32'(rsp_err_s), 32'd1);
    chk("mis_lh_rdata", rsp_rdata_s, 32'h0);
    chk("mis_lh_no_we", 32'(we_cnt), 32'd0);
    chk("mis_lh_ready_ret", 32'(ready_cyc), 32'd2);
    issue(1'b1, 2'b10, 1'b0, 32'h10010002, 32'hCAFEBABE);
    chk("mis_sw_rsp_cyc", 32'(rsp_cyc), 32'd1);
    chk("mis_sw_err", 32'(rsp_err_s), 32'd1);
    chk("mis_sw_no_we", 32'(we_cnt), 32'd0);
    load_chk("mis_sw_mem", 2'b10, 1'b0, 32'h10010000, 32'h0);

    // Reset asserted during RDW of a byte store must abort it with no write.
    issue(1'b1, 2'b10, 1'b0, 32'h10010000, 32'hA5A5A5A5);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h10010000; req_wdata = 32'h000000CD;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_ready", 32'(req_ready), 32'd1);
    chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    we_cnt = 0; rsp_cyc = -1;
    for (int c = 0; c < 4; c++) begin
      if (ram_we) we_cnt++;
      if (rsp_valid) rsp_cyc = c;
      @(negedge clk);
    end
    chk("abort_no_we", 32'(we_cnt), 32'd0);
    chk("abort_no_rsp", 32'(rsp_cyc), 32'hFFFFFFFF);
    load_chk("abort_mem", 2'b10, 1'b0, 32'h10010000, 32'hA5A5A5A5);

`ifdef LSU_RANGE_CHECK_EN
    issue(1'b1, 2'b10, 1'b0, 32'h10010100, 32'h11111111);
    chk("oor_rsp_cyc", 32'(rsp_cyc), 32'd1);
    chk("oor_err", 32'(rsp_err_s), 32'd1);
    chk("oor_no_we", 32'(we_cnt), 32'd0);
    issue(1'b1, 2'b10, 1'b0, 32'h100100FC, 32'h0BADF00D);
    chk("top_we_cyc", 32'(we_cyc), 32'd1);
    chk("top_we_addr", we_addr_s, 32'h100100FC);
    chk("top_rsp_cyc", 32'(rsp_cyc), 32'd2);
    chk("top_err", 32'(rsp_err_s), 32'd0);
`else
    issue(1'b1, 2'b10, 1'b0, 32'h10010100, 32'h11111111);
    chk("fwd_we_cyc", 32'(we_cyc), 32'd1);
    chk("fwd_we_addr", we_addr_s, 32'h10010100);
    chk("fwd_rsp_cyc", 32'(rsp_cyc), 32'd2);
    chk("fwd_err", 32'(rsp_err_s), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
